class_vote_filter: RTL and testbench

- Sits directly downstream of the XADC readout/argmax stage, which produces a raw 2-bit winning class per aux-channel conversion sweep, plus the winning 12-bit level.
- Filters that raw per-sweep decision with a sliding-window majority vote and an activity floor, so the board-level outputs (LEDs, ASIC bridge handshake) only change on a stable classification.
- Emits the committed class, an activity flag, a one-cycle change pulse and a confidence count.

---
 rtl/class_vote_filter.sv | 143 ++++++++++++++
 tb/tb_class_vote_filter.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/class_vote_filter.sv
// Sliding-window majority vote over raw per-sweep class decisions, with an
// activity floor, so downstream LEDs/handshakes only see stable classifications.
module class_vote_filter #(
  parameter int          WINDOW    = 8,
  parameter int          THRESHOLD = 5,
  parameter logic [11:0] MIN_LEVEL = 12'h100,
  parameter int          CW        = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    class_in,
  input  logic [11:0]   level_in,
  input  logic          class_valid,
  input  logic          clear,
  output logic [1:0]    decision,
  output logic          decision_active,
  output logic          decision_change,
  output logic [CW-1:0] confidence,
  output logic          window_full
);

  localparam int            FW      = $clog2(WINDOW + 1);
  localparam int            IDLE    = 4;
  localparam logic [CW-1:0] THR     = CW'(THRESHOLD);
  localparam logic [FW-1:0] FILLEND = FW'(WINDOW);

  typedef enum logic {FILL, TRACK} state_t;

  state_t        state_q, state_d;
  logic [2:0]    hist_q [WINDOW];
  logic [2:0]    hist_d [WINDOW];
  logic [CW-1:0] cnt_q  [5];
  logic [CW-1:0] cnt_d  [5];
  logic [FW-1:0] fill_q, fill_d;
  logic          wfull_q, wfull_d;
  logic [1:0]    dec_q, dec_d;
  logic          act_q, act_d;
  logic          chg_q, chg_d;

  logic [2:0] newEntry;
  logic [2:0] oldEntry;
  logic [2:0] incIdx;
  logic [2:0] decIdx;
  logic       hit;

  // Entry layout is {active, class}; inactive entries all vote into the idle counter.
  assign newEntry = {(level_in >= MIN_LEVEL), class_in};
  assign oldEntry = hist_q[WINDOW-1];
  assign incIdx   = newEntry[2] ? {1'b0, newEntry[1:0]} : 3'(IDLE);
  assign decIdx   = oldEntry[2] ? {1'b0, oldEntry[1:0]} : 3'(IDLE);

  always_comb begin
    state_d = state_q;
    hist_d  = hist_q;
    cnt_d   = cnt_q;
    fill_d  = fill_q;
    wfull_d = wfull_q;
    dec_d   = dec_q;
    act_d   = act_q;
    chg_d   = 1'b0;
    hit     = 1'b0;

    // Evaluation works on last cycle's counters, so it pipelines with the update below.
    if (state_q == TRACK) begin
      for (int c = 0; c < 4; c++) begin
        if (!hit && (cnt_q[c] >= THR)) begin
          dec_d = 2'(c);
          act_d = 1'b1;
          hit   = 1'b1;
        end
      end
      if (!hit && (cnt_q[IDLE] >= THR)) begin
        act_d = 1'b0;
      end
      chg_d = (dec_d != dec_q) || (act_d != act_q);
    end

    if (clear) begin
      state_d = FILL;
      fill_d  = '0;
      wfull_d = 1'b0;
      dec_d   = 2'd0;
      act_d   = 1'b0;
      chg_d   = 1'b0;
      for (int i = 0; i < WINDOW; i++) begin
        hist_d[i] = 3'd0;
      end
      for (int k = 0; k < 5; k++) begin
        cnt_d[k] = '0;
      end
    end else if (class_valid) begin
      hist_d[0] = newEntry;
      for (int i = 1; i < WINDOW; i++) begin
        hist_d[i] = hist_q[i-1];
      end
      cnt_d[incIdx] = cnt_q[incIdx] + CW'(1);
      // Applying the decrement on top of cnt_d makes a same-counter hit net to zero.
      if (state_q == TRACK) begin
        cnt_d[decIdx] = cnt_d[decIdx] - CW'(1);
      end
      if (state_q == FILL) begin
        fill_d = fill_q + FW'(1);
        if (fill_d == FILLEND) begin
          state_d = TRACK;
          wfull_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FILL;
      fill_q  <= '0;
      wfull_q <= 1'b0;
      dec_q   <= 2'd0;
      act_q   <= 1'b0;
      chg_q   <= 1'b0;
      for (int i = 0; i < WINDOW; i++) begin
        hist_q[i] <= 3'd0;
      end
      for (int k = 0; k < 5; k++) begin
        cnt_q[k] <= '0;
      end
    end else begin
      state_q <= state_d;
      fill_q  <= fill_d;
      wfull_q <= wfull_d;
      dec_q   <= dec_d;
      act_q   <= act_d;
      chg_q   <= chg_d;
      hist_q  <= hist_d;
      cnt_q   <= cnt_d;
    end
  end

  assign decision        = dec_q;
  assign decision_active = act_q;
  assign decision_change = chg_q;
  assign confidence      = cnt_q[{1'b0, dec_q}];
  assign window_full     = wfull_q;

endmodule

// File: tb/tb_class_vote_filter.sv
// Scoreboard bench for class_vote_filter: stimulus queues cycle-tagged
// expectations, a negedge monitor pops and compares them.
module tb_class_vote_filter;

  localparam int ID_DEC   = 0;
  localparam int ID_ACT   = 1;
  localparam int ID_CHG   = 2;
  localparam int ID_CONF  = 3;
  localparam int ID_WFULL = 4;
  localparam int ID_CNT   = 5;

  logic        clk;
  logic        rst;
  logic [1:0]  class_in;
  logic [11:0] level_in;
  logic        class_valid;
  logic        clear;
  logic [1:0]  decision;
  logic        decision_active;
  logic        decision_change;
  logic [5:0]  confidence;
  logic        window_full;

  int cyc = 0;
  int checks = 0;
  int failures = 0;

  typedef struct {
    int    tag;
    int    id;
    int    val;
    string name;
  } exp_t;
  exp_t sbq[$];

  logic [2:0] modelHist[$];
  int         modelAccepted;

  class_vote_filter #(.WINDOW(8), .THRESHOLD(5), .MIN_LEVEL(12'h100), .CW(6)) dut (
    .clk(clk), .rst(rst), .class_in(class_in), .level_in(level_in),
    .class_valid(class_valid), .clear(clear), .decision(decision),
    .decision_active(decision_active), .decision_change(decision_change),
    .confidence(confidence), .window_full(window_full)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int actualOf(input int id);
    case (id)
      ID_DEC:   return int'(decision);
      ID_ACT:   return int'(decision_active);
      ID_CHG:   return int'(decision_change);
      ID_CONF:  return int'(confidence);
      ID_WFULL: return int'(window_full);
      default:  return int'(dut.cnt_q[id-ID_CNT]);
    endcase
  endfunction

  task automatic checkOutput(input exp_t e);
    int act;
    act = actualOf(e.id);
    checks++;
    if (act != e.val) begin
      failures++;
      $display("[TB] FAIL %s cycle=%0d got=%0d expected=%0d", e.name, cyc, act, e.val);
    end
  endtask

  // Monitor: compare every expectation due this cycle, and bound all counters.
  always @(negedge clk) begin
    for (int i = sbq.size() - 1; i >= 0; i--) begin
      if (sbq[i].tag == cyc) begin
        checkOutput(sbq[i]);
        sbq.delete(i);
      end
    end
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (int'(dut.cnt_q[k]) > 8) begin
        failures++;
        $display("[TB] FAIL cntBound%0d cycle=%0d got=%0d expected<=8", k, cyc, dut.cnt_q[k]);
      end
    end
  end

  task automatic expectAt(input int off, input int id, input int val, input string name);
    sbq.push_back('{cyc + off, id, val, name});
  endtask

  task automatic expectOut(input int off, input int dec, input int act, input int chg,
                           input int conf, input string name);
    expectAt(off, ID_DEC,  dec,  {name, ".decision"});
    expectAt(off, ID_ACT,  act,  {name, ".active"});
    expectAt(off, ID_CHG,  chg,  {name, ".change"});
    expectAt(off, ID_CONF, conf, {name, ".confidence"});
  endtask

  task automatic applyStimulus(input bit v, input logic [1:0] c, input logic [11:0] l,
                               input bit clr);
    class_valid = v;
    class_in    = c;
    level_in    = l;
    clear       = clr;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 2'd0, 12'h000, 1'b0);
  endtask

  task automatic sample(input logic [1:0] c, input logic [11:0] l);
    applyStimulus(1'b1, c, l, 1'b0);
  endtask

  // Reference counts are recounted from the whole stored window every sample.
  task automatic modelPush(input logic [1:0] c, input logic [11:0] l);
    int cnts[5];
    modelHist.push_front({(l >= 12'h100), c});
    if (modelHist.size() > 8) void'(modelHist.pop_back());
    modelAccepted++;
    for (int k = 0; k < 5; k++) cnts[k] = 0;
    foreach (modelHist[j]) begin
      if (modelHist[j][2]) cnts[modelHist[j][1:0]]++;
      else cnts[4]++;
    end
    for (int k = 0; k < 5; k++) expectAt(1, ID_CNT + k, cnts[k], $sformatf("rand.cnt%0d", k));
    expectAt(1, ID_WFULL, (modelAccepted >= 8) ? 1 : 0, "rand.windowFull");
  endtask

  initial begin
    #100000;
    failures++;
    $display("[TB] FAIL watchdog cycle=%0d got=timeout expected=finish", cyc);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    logic [1:0]  rc;
    logic [11:0] rl;
    rst = 1'b1;
    class_valid = 1'b0;
    class_in = 2'd0;
    level_in = 12'h000;
    clear = 1'b0;
    @(negedge clk);
    expectOut(1, 0, 0, 0, 0, "reset");
    expectAt(1, ID_WFULL, 0, "reset.windowFull");
    expectAt(1, ID_CNT + 2, 0, "reset.cnt2");
    @(negedge clk);
    rst = 1'b0;

    // Fill with class 2: window_full with 8th sample, commit two cycles later.
    for (int i = 0; i < 8; i++) begin
      if (i == 6) expectAt(1, ID_WFULL, 0, "s1.fillNotYet");
      if (i == 7) begin
        expectAt(1, ID_WFULL, 1, "s1.windowFull");
        expectAt(1, ID_ACT, 0, "s1.activeInFill");
        expectOut(2, 2, 1, 1, 8, "s1.commit");
        expectAt(3, ID_CHG, 0, "s1.pulseEnd");
      end
      sample(2'd2, 12'h800);
    end
    idle(2);

    // Four class-1 votes hold class 2; the fifth switches to class 1.
    for (int i = 0; i < 5; i++) begin
      if (i == 3) expectOut(1, 2, 1, 0, 4, "s2.hold4");
      if (i == 4) begin
        expectOut(1, 2, 1, 0, 3, "s2.preSwitch");
        expectOut(2, 1, 1, 1, 5, "s2.switch");
        expectAt(3, ID_CHG, 0, "s2.pulseEnd");
      end
      sample(2'd1, 12'h800);
    end
    idle(2);

    // Full window of class 0, then alternating 1/3 never reaches threshold.
    for (int i = 0; i < 8; i++) begin
      if (i == 4) begin
        expectAt(2, ID_DEC, 0, "s3.commit0.decision");
        expectAt(2, ID_CHG, 1, "s3.commit0.change");
      end
      if (i == 7) expectOut(3, 0, 1, 0, 8, "s3.full0");
      sample(2'd0, 12'h800);
    end
    idle(2);
    for (int i = 0; i < 8; i++) begin
      expectAt(2, ID_CHG, 0, $sformatf("s3.alt%0d.change", i));
      expectAt(2, ID_DEC, 0, $sformatf("s3.alt%0d.decision", i));
      expectAt(2, ID_ACT, 1, $sformatf("s3.alt%0d.active", i));
      if (i == 7) begin
        expectAt(1, ID_CONF, 0, "s3.altConf");
        expectAt(1, ID_CNT + 1, 4, "s3.altCnt1");
        expectAt(1, ID_CNT + 3, 4, "s3.altCnt3");
      end
      sample((i % 2 == 0) ? 2'd1 : 2'd3, 12'h800);
    end
    idle(2);

    // Commit class 3, then five sub-floor sweeps drop activity but keep the class.
    for (int i = 0; i < 8; i++) begin
      if (i == 0) begin
        expectAt(2, ID_DEC, 3, "s4.commit3.decision");
        expectAt(2, ID_CHG, 1, "s4.commit3.change");
      end
      if (i == 7) expectOut(3, 3, 1, 0, 8, "s4.full3");
      sample(2'd3, 12'h800);
    end
    idle(2);
    for (int i = 0; i < 5; i++) begin
      if (i == 4) begin
        expectOut(1, 3, 1, 0, 3, "s4.idle4");
        expectAt(1, ID_CNT + 4, 5, "s4.idleCnt");
        expectOut(2, 3, 0, 1, 3, "s4.inactive");
        expectAt(3, ID_CHG, 0, "s4.pulseEnd");
      end
      sample(2'd2, 12'h0FF);
    end
    idle(3);

    // clear wins over a coincident sample, which must not be counted.
    expectOut(1, 0, 0, 0, 0, "s5.clear");
    expectAt(1, ID_WFULL, 0, "s5.clear.windowFull");
    expectAt(1, ID_CNT + 1, 0, "s5.clear.cnt1");
    expectAt(1, ID_CNT + 4, 0, "s5.clear.idle");
    applyStimulus(1'b1, 2'd1, 12'h800, 1'b1);
    modelHist.delete();
    modelAccepted = 0;

    for (int i = 0; i < 20; i++) begin
      rc = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0:       rl = 12'h0FF;
        1:       rl = 12'h100;
        2:       rl = 12'h800;
        default: rl = 12'($urandom_range(0, 4095));
      endcase
      modelPush(rc, rl);
      sample(rc, rl);
    end
    idle(2);

    // Asynchronous reset mid-fill, then a fresh fill from zero.
    applyStimulus(1'b0, 2'd0, 12'h000, 1'b1);
    for (int i = 0; i < 4; i++) begin
      if (i == 3) expectAt(1, ID_CONF, 4, "s6.preResetConf");
      sample(2'd0, 12'h800);
    end
    class_valid = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    expectOut(0, 0, 0, 0, 0, "s6.reset");
    expectAt(0, ID_WFULL, 0, "s6.reset.windowFull");
    expectAt(0, ID_CNT, 0, "s6.reset.cnt0");
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i == 6) expectAt(1, ID_WFULL, 0, "s6.refillNotYet");
      if (i == 7) begin
        expectAt(1, ID_WFULL, 1, "s6.refillFull");
        expectOut(2, 0, 1, 1, 8, "s6.commit");
        expectAt(3, ID_CHG, 0, "s6.pulseEnd");
      end
      sample(2'd0, 12'h800);
    end
    idle(4);

    foreach (sbq[i]) begin
      checks++;
      failures++;
      $display("[TB] FAIL %s cycle=%0d got=unchecked expected=tag%0d", sbq[i].name, cyc, sbq[i].tag);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
